scr1_mem_arb: RTL and testbench

Two-master to one-slave arbiter on the SCR1 core memory interface, placed directly upstream of the memory AXI bridge so that instruction and data traffic share one AXI port. It selects one pending master request per cycle, forwards it combinationally to the slave port, and records the granted master ID in an in-order FIFO. Responses from the slave are steered back to the recorded master.

---
 rtl/scr1_mem_arb_pkg.sv | 33 +++
 rtl/scr1_mem_arb_if.sv | 31 +++
 rtl/scr1_arb_id_fifo.sv | 67 ++++++
 rtl/scr1_mem_arb.sv | 121 ++++++++++++
 tb/tb_scr1_mem_arb.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/scr1_mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// scr1_mem_arb_pkg
// Shared memory-interface types (cmd/width/resp) plus arbiter-specific
// definitions: the master-ID type and the default outstanding-response depth.
// No ports.
// -----------------------------------------------------------------------------
package scr1_mem_arb_pkg;

    typedef enum logic {
        SCR1_MEM_CMD_RD = 1'b0,
        SCR1_MEM_CMD_WR = 1'b1
    } type_scr1_mem_cmd_e;

    typedef enum logic [1:0] {
        SCR1_MEM_WIDTH_BYTE  = 2'b00,
        SCR1_MEM_WIDTH_HWORD = 2'b01,
        SCR1_MEM_WIDTH_WORD  = 2'b10
    } type_scr1_mem_width_e;

    typedef enum logic [1:0] {
        SCR1_MEM_RESP_NOTRDY = 2'b00,
        SCR1_MEM_RESP_RDY_OK = 2'b01,
        SCR1_MEM_RESP_RDY_ER = 2'b10
    } type_scr1_mem_resp_e;

    typedef enum logic {
        SCR1_ARB_M0 = 1'b0,
        SCR1_ARB_M1 = 1'b1
    } type_scr1_arb_id_e;

    localparam int unsigned SCR1_ARB_DEPTH_DEFAULT = 2;

endpackage : scr1_mem_arb_pkg

// File: rtl/scr1_mem_arb_if.sv
// -----------------------------------------------------------------------------
// scr1_mem_arb_if
// One SCR1 core memory-interface link (request + response).
//   master modport : side issuing requests (drives req/cmd/width/addr/wdata)
//   slave  modport : side serving requests (drives req_ack/rdata/resp)
// -----------------------------------------------------------------------------
interface scr1_mem_arb_if #(
    parameter int unsigned SCR1_ADDR_WIDTH = 32
);
    import scr1_mem_arb_pkg::*;

    logic                       req;
    type_scr1_mem_cmd_e         cmd;
    type_scr1_mem_width_e       width;
    logic [SCR1_ADDR_WIDTH-1:0] addr;
    logic [31:0]                wdata;
    logic                       req_ack;
    logic [31:0]                rdata;
    type_scr1_mem_resp_e        resp;

    modport master (
        output req, cmd, width, addr, wdata,
        input  req_ack, rdata, resp
    );

    modport slave (
        input  req, cmd, width, addr, wdata,
        output req_ack, rdata, resp
    );

endinterface : scr1_mem_arb_if

// File: rtl/scr1_arb_id_fifo.sv
// -----------------------------------------------------------------------------
// scr1_arb_id_fifo
// In-order FIFO of 1-bit master IDs, DEPTH entries (power of 2, >= 2).
// Pointers wrap naturally modulo DEPTH.
//   clk, rst_n  : clock, asynchronous active-low reset
//   i_push      : write i_push_id (ignored when full)
//   i_pop       : drop head entry (ignored when empty)
//   o_head      : ID at the head
//   o_full      : DEPTH entries stored
//   o_empty     : no entries stored
// -----------------------------------------------------------------------------
module scr1_arb_id_fifo
    import scr1_mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH = SCR1_ARB_DEPTH_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_push,
    input  type_scr1_arb_id_e i_push_id,
    input  logic              i_pop,
    output type_scr1_arb_id_e o_head,
    output logic              o_full,
    output logic              o_empty
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    type_scr1_arb_id_e r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wptr;
    logic [PTR_W-1:0]  r_rptr;
    logic [CNT_W-1:0]  r_cnt;

    logic w_push;
    logic w_pop;

    assign w_push  = i_push & ~o_full;
    assign w_pop   = i_pop & ~o_empty;
    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_empty = (r_cnt == '0);
    assign o_head  = r_mem[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= SCR1_ARB_M0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_push_id;
                r_wptr        <= r_wptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule : scr1_arb_id_fifo

// File: rtl/scr1_mem_arb.sv
// -----------------------------------------------------------------------------
// scr1_mem_arb
// Two-master to one-slave arbiter on the SCR1 memory interface. One pending
// request is forwarded combinationally per cycle; granted IDs are queued in
// order and slave responses are steered back to the queued master.
//   clk, rst_n : clock, asynchronous active-low reset
//   m0, m1     : master links (slave modport)
//   s          : downstream link (master modport)
//   arb_idle   : no responses outstanding
// Build option: SCR1_MEM_ARB_FIXED_PRIO_EN -- m0 wins ties (no round-robin).
// -----------------------------------------------------------------------------
module scr1_mem_arb
    import scr1_mem_arb_pkg::*;
#(
    parameter int unsigned SCR1_ARB_DEPTH  = SCR1_ARB_DEPTH_DEFAULT,
    parameter int unsigned SCR1_ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    scr1_mem_arb_if.slave         m0,
    scr1_mem_arb_if.slave         m1,
    scr1_mem_arb_if.master        s,
    output logic                  arb_idle
);
    logic                       r_hold_vld;
    type_scr1_arb_id_e          r_hold_id;
`ifndef SCR1_MEM_ARB_FIXED_PRIO_EN
    type_scr1_arb_id_e          r_rr_last;
`endif

    type_scr1_arb_id_e          w_sel;
    logic                       w_sel_req;
    logic [SCR1_ADDR_WIDTH-1:0] w_sel_addr;
    logic                       w_accept;
    logic                       w_resp_vld;
    type_scr1_arb_id_e          w_head;
    logic                       w_fifo_full;
    logic                       w_fifo_empty;

    // A held grant pins the selection until the slave acks; with nothing
    // pending the selection defaults to m0 so the forwarded fields are stable.
    always_comb begin
        w_sel = SCR1_ARB_M0;
        if (r_hold_vld) begin
            w_sel = r_hold_id;
        end else if (m0.req && m1.req) begin
`ifdef SCR1_MEM_ARB_FIXED_PRIO_EN
            w_sel = SCR1_ARB_M0;
`else
            w_sel = (r_rr_last == SCR1_ARB_M0) ? SCR1_ARB_M1 : SCR1_ARB_M0;
`endif
        end else if (m1.req) begin
            w_sel = SCR1_ARB_M1;
        end
    end

    assign w_sel_req  = (w_sel == SCR1_ARB_M1) ? m1.req  : m0.req;
    assign w_sel_addr = (w_sel == SCR1_ARB_M1) ? m1.addr : m0.addr;

    // Full blocks the request even if a pop happens this cycle, keeping
    // s_resp out of the s_req path.
    assign s.req   = w_sel_req & ~w_fifo_full;
    assign s.cmd   = (w_sel == SCR1_ARB_M1) ? m1.cmd   : m0.cmd;
    assign s.width = (w_sel == SCR1_ARB_M1) ? m1.width : m0.width;
    assign s.addr  = w_sel_addr;
    assign s.wdata = (w_sel == SCR1_ARB_M1) ? m1.wdata : m0.wdata;

    assign w_accept   = s.req & s.req_ack;
    assign m0.req_ack = w_accept & (w_sel == SCR1_ARB_M0);
    assign m1.req_ack = w_accept & (w_sel == SCR1_ARB_M1);

    assign w_resp_vld = (s.resp != SCR1_MEM_RESP_NOTRDY) & ~w_fifo_empty;
    assign m0.resp    = (w_resp_vld && w_head == SCR1_ARB_M0) ? s.resp  : SCR1_MEM_RESP_NOTRDY;
    assign m1.resp    = (w_resp_vld && w_head == SCR1_ARB_M1) ? s.resp  : SCR1_MEM_RESP_NOTRDY;
    assign m0.rdata   = (w_resp_vld && w_head == SCR1_ARB_M0) ? s.rdata : '0;
    assign m1.rdata   = (w_resp_vld && w_head == SCR1_ARB_M1) ? s.rdata : '0;

    assign arb_idle = w_fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_vld <= 1'b0;
            r_hold_id  <= SCR1_ARB_M0;
        end else if (w_accept) begin
            r_hold_vld <= 1'b0;
        end else if (s.req) begin
            r_hold_vld <= 1'b1;
            r_hold_id  <= w_sel;
        end
    end

`ifndef SCR1_MEM_ARB_FIXED_PRIO_EN
    // Resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_last <= SCR1_ARB_M1;
        end else if (w_accept) begin
            r_rr_last <= w_sel;
        end
    end
`endif

    scr1_arb_id_fifo #(
        .DEPTH (SCR1_ARB_DEPTH)
    ) u_id_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_push    (w_accept),
        .i_push_id (w_sel),
        .i_pop     (w_resp_vld),
        .o_head    (w_head),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    a_no_orphan_resp : assert property (
        @(posedge clk) disable iff (!rst_n)
        !((s.resp != SCR1_MEM_RESP_NOTRDY) && w_fifo_empty)
    );

endmodule : scr1_mem_arb

// File: tb/tb_scr1_mem_arb.sv
module tb_scr1_mem_arb;
    import scr1_mem_arb_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic arb_idle;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    scr1_mem_arb_if #(.SCR1_ADDR_WIDTH(32)) m0_if ();
    scr1_mem_arb_if #(.SCR1_ADDR_WIDTH(32)) m1_if ();
    scr1_mem_arb_if #(.SCR1_ADDR_WIDTH(32)) s_if ();

    scr1_mem_arb #(
        .SCR1_ARB_DEPTH  (2),
        .SCR1_ADDR_WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .m0       (m0_if.slave),
        .m1       (m1_if.slave),
        .s        (s_if.master),
        .arb_idle (arb_idle)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_m0(input logic req, input type_scr1_mem_cmd_e cmd, input logic [31:0] addr);
        m0_if.req  = req;
        m0_if.cmd  = cmd;
        m0_if.addr = addr;
    endtask

    task automatic set_m1(input logic req, input type_scr1_mem_cmd_e cmd, input logic [31:0] addr,
                          input logic [31:0] wdata);
        m1_if.req   = req;
        m1_if.cmd   = cmd;
        m1_if.addr  = addr;
        m1_if.wdata = wdata;
    endtask

    task automatic set_s(input logic ack, input type_scr1_mem_resp_e resp, input logic [31:0] rdata);
        s_if.req_ack = ack;
        s_if.resp    = resp;
        s_if.rdata   = rdata;
    endtask

    task automatic chk_resp(input string tag, input type_scr1_mem_resp_e r0, input logic [31:0] d0,
                            input type_scr1_mem_resp_e r1, input logic [31:0] d1);
        chk({tag, "_m0_resp"},  32'(m0_if.resp), 32'(r0));
        chk({tag, "_m0_rdata"}, m0_if.rdata,     d0);
        chk({tag, "_m1_resp"},  32'(m1_if.resp), 32'(r1));
        chk({tag, "_m1_rdata"}, m1_if.rdata,     d1);
    endtask

    task automatic chk_req(input string tag, input logic sreq, input logic [31:0] addr,
                           input logic a0, input logic a1);
        chk({tag, "_s_req"}, 32'(s_if.req), 32'(sreq));
        if (sreq) chk({tag, "_s_addr"}, s_if.addr, addr);
        chk({tag, "_m0_ack"}, 32'(m0_if.req_ack), 32'(a0));
        chk({tag, "_m1_ack"}, 32'(m1_if.req_ack), 32'(a1));
    endtask

    initial begin
        rst_n = 1'b0;
        m0_if.width = SCR1_MEM_WIDTH_WORD;
        m1_if.width = SCR1_MEM_WIDTH_WORD;
        m0_if.wdata = 32'h0;
        set_m0(1'b0, SCR1_MEM_CMD_RD, 32'h0);
        set_m1(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
        set_s(1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);

        // Reset, masters idle
        @(negedge clk); #1;
        chk_req("rst", 1'b0, 32'h0, 1'b0, 1'b0);
        chk_resp("rst", SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        chk("rst_idle", 32'(arb_idle), 32'd1);
        next_cyc();
        rst_n = 1'b1;

        // Both masters reading, slave acks every cycle: m0, m1, m0, m1
        set_m0(1'b1, SCR1_MEM_CMD_RD, 32'h100);
        set_m1(1'b1, SCR1_MEM_CMD_RD, 32'h200, 32'h0);
        set_s(1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #1 chk_req("rr1", 1'b1, 32'h100, 1'b1, 1'b0);
        next_cyc();
        set_s(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h11);
        #1 chk_req("rr2", 1'b1, 32'h200, 1'b0, 1'b1);
        chk_resp("rr2", SCR1_MEM_RESP_RDY_OK, 32'h11, SCR1_MEM_RESP_NOTRDY, 32'h0);
        next_cyc();
        set_s(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h22);
        #1 chk_req("rr3", 1'b1, 32'h100, 1'b1, 1'b0);
        chk_resp("rr3", SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h22);
        next_cyc();
        set_s(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h33);
        #1 chk_req("rr4", 1'b1, 32'h200, 1'b0, 1'b1);
        chk_resp("rr4", SCR1_MEM_RESP_RDY_OK, 32'h33, SCR1_MEM_RESP_NOTRDY, 32'h0);
        next_cyc();
        set_m0(1'b0, SCR1_MEM_CMD_RD, 32'h0);
        set_m1(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
        set_s(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h44);
        #1 chk_req("rr5", 1'b0, 32'h0, 1'b0, 1'b0);
        chk_resp("rr5", SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h44);
        chk("rr5_idle", 32'(arb_idle), 32'd0);
        next_cyc();

        // Hold: m1 write stalled 3 cycles while m0 starts requesting
        set_s(1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        set_m1(1'b1, SCR1_MEM_CMD_WR, 32'h300, 32'hDEAD);
        #1 chk("hold0_idle", 32'(arb_idle), 32'd1);
        chk_req("hold0", 1'b1, 32'h300, 1'b0, 1'b0);
        chk("hold0_cmd", 32'(s_if.cmd), 32'(SCR1_MEM_CMD_WR));
        next_cyc();
        set_m0(1'b1, SCR1_MEM_CMD_RD, 32'h400);
        #1 chk_req("hold1", 1'b1, 32'h300, 1'b0, 1'b0);
        chk("hold1_wdata", s_if.wdata, 32'hDEAD);
        next_cyc();
        #1 chk_req("hold2", 1'b1, 32'h300, 1'b0, 1'b0);
        next_cyc();
        set_s(1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #1 chk_req("hold3", 1'b1, 32'h300, 1'b0, 1'b1);
        next_cyc();
        set_m1(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
        #1 chk_req("hold4", 1'b1, 32'h400, 1'b1, 1'b0);
        next_cyc();
        set_m0(1'b0, SCR1_MEM_CMD_RD, 32'h0);
        set_s(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h55);
        #1 chk_resp("hold5", SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'h55);
        next_cyc();
        set_s(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h66);
        #1 chk_resp("hold6", SCR1_MEM_RESP_RDY_OK, 32'h66, SCR1_MEM_RESP_NOTRDY, 32'h0);
        next_cyc();

        // Depth 2 full: third request blocked, pop that cycle, request next cycle
        set_s(1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        set_m0(1'b1, SCR1_MEM_CMD_RD, 32'h500);
        #1 chk("full0_idle", 32'(arb_idle), 32'd1);
        chk_req("full0", 1'b1, 32'h500, 1'b1, 1'b0);
        next_cyc();
        set_m0(1'b1, SCR1_MEM_CMD_RD, 32'h504);
        #1 chk_req("full1", 1'b1, 32'h504, 1'b1, 1'b0);
        next_cyc();
        set_m0(1'b1, SCR1_MEM_CMD_RD, 32'h508);
        set_s(1'b1, SCR1_MEM_RESP_RDY_OK, 32'h77);
        #1 chk_req("full2", 1'b0, 32'h0, 1'b0, 1'b0);
        chk_resp("full2", SCR1_MEM_RESP_RDY_OK, 32'h77, SCR1_MEM_RESP_NOTRDY, 32'h0);
        next_cyc();
        set_s(1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #1 chk_req("full3", 1'b1, 32'h508, 1'b1, 1'b0);
        next_cyc();
        set_m0(1'b0, SCR1_MEM_CMD_RD, 32'h0);
        set_s(1'b0, SCR1_MEM_RESP_RDY_OK, 32'h88);
        #1 chk_resp("full4", SCR1_MEM_RESP_RDY_OK, 32'h88, SCR1_MEM_RESP_NOTRDY, 32'h0);
        next_cyc();

        // Error response on an m0 read
        set_s(1'b0, SCR1_MEM_RESP_RDY_ER, 32'h99);
        #1 chk_resp("err", SCR1_MEM_RESP_RDY_ER, 32'h99, SCR1_MEM_RESP_NOTRDY, 32'h0);
        chk("err_idle_before", 32'(arb_idle), 32'd0);
        next_cyc();
        set_s(1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #1 chk("err_idle_after", 32'(arb_idle), 32'd1);

        // Reset with two outstanding, then m1 traffic after release
        set_m0(1'b1, SCR1_MEM_CMD_RD, 32'h600);
        next_cyc();
        set_m0(1'b1, SCR1_MEM_CMD_RD, 32'h604);
        next_cyc();
        set_m0(1'b0, SCR1_MEM_CMD_RD, 32'h0);
        set_s(1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #1 chk("mrst_idle_before", 32'(arb_idle), 32'd0);
        #1 rst_n = 1'b0;
        #1 chk("mrst_idle_async", 32'(arb_idle), 32'd1);
        next_cyc();
        rst_n = 1'b1;
        set_m1(1'b1, SCR1_MEM_CMD_RD, 32'h700, 32'h0);
        set_s(1'b1, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #1 chk_req("mrst1", 1'b1, 32'h700, 1'b0, 1'b1);
        next_cyc();
        set_m1(1'b0, SCR1_MEM_CMD_RD, 32'h0, 32'h0);
        set_s(1'b0, SCR1_MEM_RESP_RDY_OK, 32'hAB);
        #1 chk_resp("mrst2", SCR1_MEM_RESP_NOTRDY, 32'h0, SCR1_MEM_RESP_RDY_OK, 32'hAB);
        next_cyc();
        set_s(1'b0, SCR1_MEM_RESP_NOTRDY, 32'h0);
        #1 chk("mrst3_idle", 32'(arb_idle), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_scr1_mem_arb
